sim_mmio_console: RTL
=====================

Name: sim_mmio_console

Overview:
- Parametrised memory-mapped simulation peripheral for the RS5 SoC bench; it is the successor to the bench's ad-hoc output/end registers.
- Adds:
  - N console channels sharing a tagged TX FIFO, drained over a valid/ready character stream;
  - a 64-bit cycle counter with atomic high-word snapshot;
  - an END register carrying an exit code, with drain-before-finish;
  - a drain timeout.
- Sits on the core's data bus beside RAM_mem, rtc and plic, selected by the bench address decoder.

Parameters:
- CHANNELS, 2, number of console channels (1..16).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before a forced finish (>= 1).
- ADDR_WIDTH, 12, number of address bits decoded.

Ports:
- clk  in  1  clock, all logic on rising edge.
- sys_reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  bus access select for this block.
- we_i  in  4  byte write enables; all zero means read.
- addr_i  in  ADDR_WIDTH  byte address, word aligned.
- data_i  in  32  write data.
- data_o  out  32  read data, registered.
- char_valid_o  out  1  character stream valid.
- char_ready_i  in  1  character stream ready (bench sink).
- char_o  out  8  character byte.
- char_ch_o  out  4  source channel of char_o.
- finish_o  out  1  simulation may end; sticky.
- exit_code_o  out  8  latched exit code.
- timeout_o  out  1  finish was forced by the drain timeout.

Behaviour:
- Reset:
  - One clock, synchronous, active-high reset on sys_reset_i.
  - While sys_reset_i is high: all outputs 0, FIFO empty, counter 0, overflow flag 0, state RUN.
  - Reset asserted mid-drain aborts the drain; FIFO contents are discarded.
- Bus rules:
  - A write is en_i=1 with we_i!=0; a read is en_i=1 with we_i=0.
  - data_o is valid exactly 1 cycle after a read and holds that value until the next read.
  - Reads of unmapped addresses return 0; writes to unmapped addresses are ignored.
- Register map:
  - 0x000 END
    - W: exit_code<=data_i[7:0]; state RUN->DRAIN. Ignored unless in RUN.
    - R: 0.
  - 0x004 STATUS
    - R: [0] empty, [1] full, [2] overflow (sticky), [3] draining, [4] finish, [15:8] FIFO count, others 0.
    - W: data_i[2]=1 clears overflow.
  - 0x008 CYCLE_LO
    - R: counter[31:0]; in the same cycle, snapshots counter[63:32] into hi_snap.
  - 0x00C CYCLE_HI
    - R: hi_snap.
  - 0x100+4*c TX channel c, for c<CHANNELS
    - W with we_i[0]=1: push {c, data_i[7:0]}.
    - R: 0.
    - c>=CHANNELS behaves as unmapped.
- Cycle counter:
  - 64 bits, +1 every cycle with reset low; wraps to 0 after all-ones.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full is dropped and sets overflow, unless a pop occurs the same cycle; in that case the push is accepted and count is unchanged.
  - Push and pop in the same cycle on a non-full FIFO leave count unchanged.
- Character stream:
  - char_valid_o = !empty; char_o/char_ch_o show the FIFO head.
  - Pop on char_valid_o && char_ready_i.
  - Head is stable while valid && !ready.
  - First push to an empty FIFO is visible on the next cycle.
- FSM:
  - RUN: normal operation; END write -> DRAIN.
  - DRAIN:
    - TX writes are dropped and do not set overflow; the timer counts cycles.
    - FIFO empty -> DONE.
    - Timer reaching DRAIN_TIMEOUT with FIFO non-empty -> DONE, timeout_o=1.
  - DONE:
    - finish_o=1, exit_code_o valid, char_valid_o=0; remaining FIFO entries are frozen.
    - Leaves DONE only on reset.
  - END write in RUN with an empty FIFO: DRAIN for exactly 1 cycle, finish_o rises 2 cycles after the write cycle.

Decomposition:
- RS5_pkg gains:
  - register offset localparams (END, STATUS, CYCLE_LO, CYCLE_HI, TX_BASE);
  - console_state_e {RUN, DRAIN, DONE};
  - a packed struct {ch[3:0], byte[7:0]} for FIFO entries.
- One sub-module: sim_fifo, a generic DEPTH/WIDTH synchronous FIFO with push/pop/full/empty/count and the simultaneous push/pop-on-full rule.
- Bus decode, the counter and the FSM stay in the top module.

Test Plan:
- Reset held 3 cycles, then release → all outputs 0; CYCLE_LO read on the 10th cycle after release returns 10 (±1 per documented counting origin); STATUS reads 0x0000_0001.
- With char_ready_i=1: write 'A' to ch0 (0x100) and 'B' to ch1 (0x104) on consecutive cycles → stream emits {0,'A'} then {1,'B'}, one per cycle; STATUS returns to empty.
- With char_ready_i=0: write 17 bytes to ch0 (FIFO_DEPTH=16) → count=16, STATUS[2]=1, 17th byte lost. Write STATUS data 0x4 → overflow clears.
- Preload counter to 0x0000_0000_FFFF_FFFF by force, then wait 1 cycle → CYCLE_LO read returns 0x0, next CYCLE_HI read returns 0x1; HI stays stable even if read later.
- 3 bytes queued with ready low, END write 0x2A, ready raised 5 cycles later → all 3 bytes emitted, then finish_o=1, exit_code_o=0x2A, timeout_o=0. TX writes made during the drain are not emitted.
- DRAIN_TIMEOUT=8, ready held low, 2 bytes queued, END write 0x01 → finish_o=1 and timeout_o=1 after 8 DRAIN cycles. Asserting sys_reset_i mid-DRAIN in a repeat run → immediate RUN, FIFO empty.

Source files
------------

// File: rtl/sim_mmio_console_pkg.sv
// Shared types and register offsets for the simulation MMIO console.
// Offsets are byte addresses relative to the block's base.
package sim_mmio_console_pkg;

  localparam logic [31:0] REG_END      = 32'h000;
  localparam logic [31:0] REG_STATUS   = 32'h004;
  localparam logic [31:0] REG_CYCLE_LO = 32'h008;
  localparam logic [31:0] REG_CYCLE_HI = 32'h00C;
  localparam logic [31:0] REG_TX_BASE  = 32'h100;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } console_state_e;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] chr;
  } fifo_entry_t;

  function automatic logic [31:0] status_word(
    input logic       empty,
    input logic       full,
    input logic       overflow,
    input logic       draining,
    input logic       finish,
    input logic [7:0] count
  );
    status_word = {16'h0000, count, 3'b000, finish, draining, overflow, full, empty};
  endfunction

endpackage

// File: rtl/sim_fifo.sv
// Generic synchronous FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and flagged.
module sim_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       sys_reset_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sim_mmio_console.sv
// Memory-mapped simulation console: tagged multi-channel TX FIFO drained over
// a valid/ready stream, 64-bit cycle counter, and END register with drain.
module sim_mmio_console
  import sim_mmio_console_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int ADDR_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  sys_reset_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  char_valid_o,
  input  logic                  char_ready_i,
  output logic [7:0]            char_o,
  output logic [3:0]            char_ch_o,
  output logic                  finish_o,
  output logic [7:0]            exit_code_o,
  output logic                  timeout_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    addr_w;
  logic           wr_en;
  logic           rd_en;
  logic           end_wr;
  logic           status_wr;
  logic           tx_hit;
  logic [3:0]     tx_ch;

  console_state_e state;
  console_state_e state_next;
  logic           timeout_hit;
  logic [31:0]    drain_timer;

  logic [63:0]    cycle_cnt;
  logic [31:0]    hi_snap;
  logic [31:0]    rdata;
  logic [31:0]    data_q;
  logic           overflow_q;
  logic           timeout_q;
  logic [7:0]     exit_code_q;

  fifo_entry_t    push_entry;
  fifo_entry_t    head;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_drop;
  logic [CW-1:0]  fifo_count;
  logic           stream_valid;

  // Bus decode
  assign addr_w    = 32'(addr_i);
  assign wr_en     = en_i && (we_i != 4'b0000);
  assign rd_en     = en_i && (we_i == 4'b0000);
  assign end_wr    = wr_en && (addr_w == REG_END);
  assign status_wr = wr_en && (addr_w == REG_STATUS);
  assign tx_hit    = (addr_w >= REG_TX_BASE) && (addr_w < REG_TX_BASE + 32'(4 * CHANNELS));
  assign tx_ch     = addr_w[5:2];

  // TX pushes only land while running; in DRAIN and DONE they vanish silently.
  assign fifo_push  = wr_en && tx_hit && we_i[0] && (state == RUN);
  assign push_entry = '{ch: tx_ch, chr: data_i[7:0]};
  assign fifo_pop   = stream_valid && char_ready_i;

  sim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk         (clk),
    .sys_reset_i (sys_reset_i),
    .push        (fifo_push),
    .push_data   (push_entry),
    .pop         (fifo_pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .dropped     (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (sys_reset_i) cycle_cnt <= '0;
    else             cycle_cnt <= cycle_cnt + 64'd1;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (sys_reset_i) state <= RUN;
    else             state <= state_next;
  end

  // FSM: next state. An empty FIFO wins over a simultaneous timer expiry.
  // NOTE: every combinational output gets a default first so no path
  // through the block can infer a latch.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      RUN: begin
        if (end_wr) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = DONE;
        end else if (drain_timer == 32'(DRAIN_TIMEOUT - 1)) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  // FSM: outputs. Everything is forced low while reset is held.
  always_comb begin
    stream_valid = !fifo_empty && (state != DONE);
    char_valid_o = stream_valid && !sys_reset_i;
    char_o       = sys_reset_i ? 8'h00 : head.chr;
    char_ch_o    = sys_reset_i ? 4'h0 : head.ch;
    finish_o     = (state == DONE) && !sys_reset_i;
    timeout_o    = timeout_q && !sys_reset_i;
    exit_code_o  = sys_reset_i ? 8'h00 : exit_code_q;
    data_o       = sys_reset_i ? 32'h0 : data_q;
  end

  always_ff @(posedge clk) begin
    if (sys_reset_i || (state != DRAIN)) drain_timer <= '0;
    else                                 drain_timer <= drain_timer + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      timeout_q   <= 1'b0;
      exit_code_q <= 8'h00;
    end else begin
      if ((state == DRAIN) && timeout_hit) timeout_q <= 1'b1;
      if ((state == RUN) && end_wr)        exit_code_q <= data_i[7:0];
    end
  end

  // A fresh drop takes priority over a clear issued in the same cycle.
  always_ff @(posedge clk) begin
    if (sys_reset_i)                  overflow_q <= 1'b0;
    else if (fifo_drop)               overflow_q <= 1'b1;
    else if (status_wr && data_i[2])  overflow_q <= 1'b0;
  end

  always_comb begin
    rdata = 32'h0;
    case (addr_w)
      REG_STATUS:   rdata = status_word(fifo_empty, fifo_full, overflow_q,
                                        state == DRAIN, state == DONE, 8'(fifo_count));
      REG_CYCLE_LO: rdata = cycle_cnt[31:0];
      REG_CYCLE_HI: rdata = hi_snap;
      default:      rdata = 32'h0;
    endcase
  end

  // Read data holds until the next read; a CYCLE_LO read freezes the high
  // word so a following CYCLE_HI read is consistent with it.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      data_q  <= 32'h0;
      hi_snap <= 32'h0;
    end else if (rd_en) begin
      data_q <= rdata;
      if (addr_w == REG_CYCLE_LO) hi_snap <= cycle_cnt[63:32];
    end
  end

endmodule
